sub_bytes_pipe: RTL
===================

Name: sub_bytes_pipe

Overview:
Multi-lane, pipelined AES byte-substitution engine supporting both the forward S-box (SubBytes) and the inverse S-box (InvSubBytes), selected per beat. It sits between the state register and ShiftRows/MixColumns in the AES round datapath. It replaces the single-byte, purely combinational substitution with LANES parallel bytes, a configurable register depth and a valid/ready handshake with full backpressure.

Parameters:
- LANES, 16, number of independent byte lanes per beat (1..16); 16 = full AES state, 4 = one column/key-schedule word.
- PIPE_STAGES, 2, register stages from input acceptance to output (1..4); output is always registered.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  engine can accept a beat this cycle.
- in_data  input  8*LANES  lane i = in_data[8i+7:8i].
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box, sampled with the beat.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  8*LANES  substituted bytes, lane order preserved.
- out_inv  output  1  mode bit that travelled with the beat.
- busy  output  1  OR of all stage valid flags.

Behaviour:
- Transfer rules: an input transfer occurs on in_valid && in_ready; an output transfer occurs on out_valid && out_ready.
- Per-lane function:
  - forward: out = S(in);
  - inverse: out = S^-1(in);
  - bit-exact to FIPS-197 tables for all 256 values;
  - lanes are fully independent.
- Internal structure:
  - the GF(2^8) inversion core is shared by both modes;
  - the inverse mode applies the inverse affine map before the core, the forward mode applies the forward affine map after it;
  - the implementation may split the logic across stages freely, provided the stage count equals PIPE_STAGES.
- Pipeline: PIPE_STAGES stages, each holding {valid, inv, data}. Stage k loads from stage k-1 when stage k is empty, or stage k's contents advance in the same cycle.
- Ready logic:
  - in_ready = !v[0] || (stage 0 advances this cycle);
  - in_ready is combinationally dependent on out_ready through the advance chain;
  - there is no combinational path from in_valid to in_ready.
- Latency and throughput:
  - with out_ready held at 1, a beat accepted in cycle n appears with out_valid=1 in cycle n+PIPE_STAGES;
  - throughput is one beat per cycle.
- Bubble collapse: empty stages are filled while the output is stalled. With out_ready=0, the engine accepts up to PIPE_STAGES beats, then deasserts in_ready.
- Backpressure: while out_valid && !out_ready, out_data, out_inv and out_valid hold stable.
- Simultaneous events: a full pipeline accepts a new beat in the same cycle the output transfers; no bubble is inserted.
- Mode switching: mode may change on every beat. Beats of mixed mode in flight are each processed in their own mode. There is no flush or drain requirement.
- Ordering: beats leave in acceptance order; no drop and no duplication.
- Reset:
  - all stage valids clear, so out_valid=0 and busy=0;
  - out_data=0, out_inv=0;
  - in_ready=1 in the first cycle after rst deasserts;
  - reset mid-operation discards every in-flight beat;
  - a beat presented in the same cycle as rst=1 is not accepted.
- No X propagation: data registers may be loaded only when the stage valid is set. When out_valid=0 the data outputs are don't-care, except after reset, where they are 0.

Test Plan:
- Known values, LANES=16, PIPE_STAGES=2, out_ready=1: lanes {0x00, 0x01, 0x53, 0xFF, ...} forward -> {0x63, 0x7C, 0xED, 0x16}; the same beat with in_inv=1 -> {0x52, 0x09, 0x50, 0x7D}; out_valid is asserted exactly 2 cycles after acceptance.
- Exhaustive round trip: stream all 256 byte values forward, then feed the results back inverse -> the original byte in every lane. Repeat with PIPE_STAGES=1 and 4 and with LANES=4.
- Backpressure: out_ready=0, 5 beats offered, PIPE_STAGES=2 -> exactly 2 accepted, then in_ready=0 and out_data stable. Release out_ready -> 5 beats out in order, one per cycle, none lost.
- Alternating mode: back-to-back beats with in_inv=0,1,0,1 and random out_ready -> each out_data and out_inv match the per-beat reference model.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> the next cycle has out_valid=0, busy=0, out_data=0, in_ready=1; the first post-reset beat emerges after PIPE_STAGES cycles with correct data.
- Full-pipe simultaneous in/out: pipeline full, out_ready=1 and in_valid=1 every cycle for 10 cycles -> in_ready remains 1 throughout and 10 results are produced with no gaps.

Source files
------------

// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe: LANES-wide AES SubBytes / InvSubBytes engine with a
// PIPE_STAGES-deep valid/ready pipeline and full backpressure.
module sub_bytes_pipe #(
    parameter int LANES       = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv,
    output logic               busy
);

    localparam int DW   = 8 * LANES;
    localparam int LAST = PIPE_STAGES - 1;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // Forward affine map applied after the field inversion.
    function automatic logic [7:0] fwd_affine(input logic [7:0] x);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    // Inverse affine map applied before the field inversion.
    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
    endfunction

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Mode-dependent front half: inverse beats get the inverse affine map.
    function automatic logic [DW-1:0] pre_map(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[8*i +: 8] = inv ? inv_affine(d[8*i +: 8]) : d[8*i +: 8];
        return r;
    endfunction

    // Shared inversion core, then the forward affine map for forward beats.
    function automatic logic [DW-1:0] post_map(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] r;
        logic [7:0]    g;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            g           = gf_inv(d[8*i +: 8]);
            r[8*i +: 8] = inv ? g : fwd_affine(g);
        end
        return r;
    endfunction

    logic [PIPE_STAGES-1:0] vld_p;
    logic [PIPE_STAGES-1:0] inv_p;
    logic [DW-1:0]          data_p [PIPE_STAGES];

    logic [PIPE_STAGES-1:0] take;
    logic [PIPE_STAGES-1:0] src_v;
    logic [PIPE_STAGES-1:0] src_i;
    logic [DW-1:0]          src_d  [PIPE_STAGES];

    // A stage can load when it is empty or its contents move on this cycle.
    always_comb begin
        logic t;
        take = '0;
        t    = out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            t       = !vld_p[k] || t;
            take[k] = t;
        end
    end

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        logic [DW-1:0] pre_d;
        if (k == 0) begin : g_head
            assign src_v[k] = in_valid;
            assign src_i[k] = in_inv;
            assign pre_d    = pre_map(in_data, in_inv);
        end else begin : g_body
            assign src_v[k] = vld_p[k-1];
            assign src_i[k] = inv_p[k-1];
            assign pre_d    = data_p[k-1];
        end
        if (k == LAST) begin : g_tail
            assign src_d[k] = post_map(pre_d, src_i[k]);
        end else begin : g_mid
            assign src_d[k] = pre_d;
        end
    end

    // Stage valid flags: cleared by reset, otherwise follow the upstream valid on load.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PIPE_STAGES; k++) begin
            if (rst)          vld_p[k] <= 1'b0;
            else if (take[k]) vld_p[k] <= src_v[k];
        end
    end

    // Stage payloads load only with a real beat; the output stage clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p[LAST] <= '0;
            inv_p[LAST]  <= 1'b0;
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (take[k] && src_v[k]) begin
                    data_p[k] <= src_d[k];
                    inv_p[k]  <= src_i[k];
                end
            end
        end
    end

    assign in_ready  = take[0];
    assign out_valid = vld_p[LAST];
    assign out_data  = data_p[LAST];
    assign out_inv   = inv_p[LAST];
    assign busy      = |vld_p;

endmodule
